// File: rtl/fpu_issue_queue_pkg.sv
// Shared FPU opcode, queue-entry types and operand-class helpers, used by both the issue
// queue and the FPU controller.
package fpu_pkg;

    localparam int REG_NUM    = 32;
    localparam int RW         = $clog2(REG_NUM);
    localparam int INST_NUM_W = 32;

    typedef enum logic [3:0] {
        OP_FADD   = 4'd0,
        OP_FSUB   = 4'd1,
        OP_FMUL   = 4'd2,
        OP_FSQRT  = 4'd3,
        OP_FISQRT = 4'd4,
        OP_FINV   = 4'd5,
        OP_FLOOR  = 4'd6,
        OP_FTOI   = 4'd7,
        OP_ITOF   = 4'd8,
        OP_FDIV   = 4'd9
    } fpu_op_t;

    typedef logic [RW-1:0] reg_addr_t;

    typedef struct packed {
        fpu_op_t                 op;
        reg_addr_t               rs1;
        reg_addr_t               rs2;
        reg_addr_t               rd;
        logic [INST_NUM_W-1:0]   inst_number;
    } iq_entry_t;

    function automatic logic op_uses_rs2(input fpu_op_t op);
        return op inside {OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV};
    endfunction

    function automatic logic op_rs1_is_int(input fpu_op_t op);
        return op == OP_ITOF;
    endfunction

    function automatic logic op_rd_is_int(input fpu_op_t op);
        return op == OP_FTOI;
    endfunction

endpackage

// File: rtl/fpu_issue_queue_if.sv
// Bundle of decode, regfile, scoreboard, writeback and FPU-issue signals around the queue.
// slave = the queue's view, master = the surrounding pipeline's view.
interface fpu_issue_queue_if;
    import fpu_pkg::*;

    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [3:0]              in_control;
    reg_addr_t               in_rs1;
    reg_addr_t               in_rs2;
    reg_addr_t               in_rd;
    logic [INST_NUM_W-1:0]   in_inst_number;
    logic [REG_NUM-1:0]      fp_busy;
    logic [REG_NUM-1:0]      int_busy;
    reg_addr_t               fp_raddr_a;
    reg_addr_t               fp_raddr_b;
    logic [31:0]             fp_rdata_a;
    logic [31:0]             fp_rdata_b;
    reg_addr_t               int_raddr;
    logic [31:0]             int_rdata;
    logic                    wb_fp_en;
    logic                    wb_int_en;
    reg_addr_t               wb_addr;
    logic [31:0]             wb_data;
    logic                    fp_sb_set_en;
    logic                    int_sb_set_en;
    reg_addr_t               sb_set_addr;
    logic                    fpu_start;
    logic [3:0]              fpu_control;
    logic [31:0]             operand_a;
    logic [31:0]             operand_b;
    reg_addr_t               register_destination;
    logic [INST_NUM_W-1:0]   fpu_inst_number;

    modport slave (
        input  flush, in_valid, in_control, in_rs1, in_rs2, in_rd, in_inst_number,
        input  fp_busy, int_busy, fp_rdata_a, fp_rdata_b, int_rdata,
        input  wb_fp_en, wb_int_en, wb_addr, wb_data,
        output in_ready, fp_raddr_a, fp_raddr_b, int_raddr,
        output fp_sb_set_en, int_sb_set_en, sb_set_addr,
        output fpu_start, fpu_control, operand_a, operand_b,
        output register_destination, fpu_inst_number
    );

    modport master (
        output flush, in_valid, in_control, in_rs1, in_rs2, in_rd, in_inst_number,
        output fp_busy, int_busy, fp_rdata_a, fp_rdata_b, int_rdata,
        output wb_fp_en, wb_int_en, wb_addr, wb_data,
        input  in_ready, fp_raddr_a, fp_raddr_b, int_raddr,
        input  fp_sb_set_en, int_sb_set_en, sb_set_addr,
        input  fpu_start, fpu_control, operand_a, operand_b,
        input  register_destination, fpu_inst_number
    );

endinterface

// File: rtl/fpu_issue_queue_hazard_check.sv
// Combinational RAW/WAW readiness and operand selection for the head entry of the
// issue queue; a matching same-class writeback both unblocks and supplies the operand.
module fpu_hazard_check
    import fpu_pkg::*;
(
    input  logic                head_valid_i,
    input  logic                hold_i,
    input  fpu_op_t             op_i,
    input  reg_addr_t           rs1_i,
    input  reg_addr_t           rs2_i,
    input  reg_addr_t           rd_i,
    input  logic [REG_NUM-1:0]  fp_busy_i,
    input  logic [REG_NUM-1:0]  int_busy_i,
    input  logic [31:0]         fp_rdata_a_i,
    input  logic [31:0]         fp_rdata_b_i,
    input  logic [31:0]         int_rdata_i,
    input  logic                wb_fp_en_i,
    input  logic                wb_int_en_i,
    input  reg_addr_t           wb_addr_i,
    input  logic [31:0]         wb_data_i,
    output logic                issue_o,
    output logic [31:0]         operand_a_o,
    output logic [31:0]         operand_b_o
);

    logic rs1_int, rd_int, uses_rs2;
    logic fwd_a, fwd_b, busy_a, rdy_a, rdy_b, rdy_d;

    assign rs1_int  = op_rs1_is_int(op_i);
    assign rd_int   = op_rd_is_int(op_i);
    assign uses_rs2 = op_uses_rs2(op_i);

    assign fwd_a  = rs1_int ? (wb_int_en_i && wb_addr_i == rs1_i)
                            : (wb_fp_en_i  && wb_addr_i == rs1_i);
    assign busy_a = rs1_int ? int_busy_i[rs1_i] : fp_busy_i[rs1_i];
    assign rdy_a  = !busy_a || fwd_a;

    // rs2 is always an fp register when it is used at all.
    assign fwd_b = wb_fp_en_i && wb_addr_i == rs2_i;
    assign rdy_b = !uses_rs2 || !fp_busy_i[rs2_i] || fwd_b;

    assign rdy_d = rd_int ? (!int_busy_i[rd_i] || (wb_int_en_i && wb_addr_i == rd_i))
                          : (!fp_busy_i[rd_i]  || (wb_fp_en_i  && wb_addr_i == rd_i));

    assign issue_o = head_valid_i && rdy_a && rdy_b && rdy_d && !hold_i;

    always_comb begin
        operand_a_o = '0;
        operand_b_o = '0;
        if (issue_o) begin
            if (fwd_a)
                operand_a_o = wb_data_i;
            else
                operand_a_o = rs1_int ? int_rdata_i : fp_rdata_a_i;
            if (uses_rs2)
                operand_b_o = fwd_b ? wb_data_i : fp_rdata_b_i;
        end
    end

endmodule

// File: rtl/fpu_issue_queue.sv
// In-order FP issue queue: DEPTH-entry FIFO whose head issues to the FPU once its
// sources and destination clear the scoreboards, marking the destination busy.
module fpu_issue_queue
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    fpu_issue_queue_if.slave    bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    iq_entry_t          mem_q [DEPTH];
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q,  count_d;

    iq_entry_t          in_entry;
    iq_entry_t          head;
    logic               empty, enq, issue, rd_int;
    logic [31:0]        operand_a, operand_b;

    assign in_entry = '{op:          fpu_op_t'(bus.in_control),
                        rs1:         bus.in_rs1,
                        rs2:         bus.in_rs2,
                        rd:          bus.in_rd,
                        inst_number: bus.in_inst_number};

    assign empty        = (count_q == '0);
    assign bus.in_ready = (count_q != CW'(DEPTH));
    assign enq          = bus.in_valid && bus.in_ready && !bus.flush;
    assign head         = mem_q[rd_ptr_q];
    assign rd_int       = op_rd_is_int(head.op);

    // Reset is folded into the hold so a ready head cannot fire while state is cleared.
    fpu_hazard_check u_hazard (
        .head_valid_i (!empty),
        .hold_i       (bus.flush || rst),
        .op_i         (head.op),
        .rs1_i        (head.rs1),
        .rs2_i        (head.rs2),
        .rd_i         (head.rd),
        .fp_busy_i    (bus.fp_busy),
        .int_busy_i   (bus.int_busy),
        .fp_rdata_a_i (bus.fp_rdata_a),
        .fp_rdata_b_i (bus.fp_rdata_b),
        .int_rdata_i  (bus.int_rdata),
        .wb_fp_en_i   (bus.wb_fp_en),
        .wb_int_en_i  (bus.wb_int_en),
        .wb_addr_i    (bus.wb_addr),
        .wb_data_i    (bus.wb_data),
        .issue_o      (issue),
        .operand_a_o  (operand_a),
        .operand_b_o  (operand_b)
    );

    assign bus.fp_raddr_a           = issue ? head.rs1 : '0;
    assign bus.fp_raddr_b           = issue ? head.rs2 : '0;
    assign bus.int_raddr            = issue ? head.rs1 : '0;
    assign bus.fpu_start            = issue;
    assign bus.fpu_control          = issue ? head.op : 4'd0;
    assign bus.operand_a            = operand_a;
    assign bus.operand_b            = operand_b;
    assign bus.register_destination = issue ? head.rd : '0;
    assign bus.fpu_inst_number      = issue ? head.inst_number : '0;
    assign bus.fp_sb_set_en         = issue && !rd_int;
    assign bus.int_sb_set_en        = issue && rd_int;
    assign bus.sb_set_addr          = issue ? head.rd : '0;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq)
                wr_ptr_d = wr_ptr_q + PW'(1);
            if (issue)
                rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(enq) - CW'(issue);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry payload carries no reset; validity is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (enq)
            mem_q[wr_ptr_q] <= in_entry;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(enq && count_q == CW'(DEPTH)));
            assert (!(bus.fp_sb_set_en && bus.int_sb_set_en));
        end
    end

endmodule
